// File: rtl/fp_loader_pkg.sv
// Shared types and helpers for the FP operand loader.
package fp_loader_pkg;

  // Width of one keypad key code.
  localparam int KEY_W = 4;

  // Operand-entry FSM encoding; 2'd3 is unused and recovers to ENTER_A.
  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    ISSUE   = 2'd2
  } phase_e;

  // Saturating increment of a 3-bit digit counter.
  function automatic logic [2:0] sat_inc(input logic [2:0] cnt, input logic [2:0] lim);
    logic [2:0] res;
    if (cnt < lim) begin
      res = cnt + 3'd1;
    end else begin
      res = lim;
    end
    return res;
  endfunction

endpackage

// File: rtl/hex_entry_reg.sv
// Hex entry shift register with a saturating count of keys entered.
module hex_entry_reg
  import fp_loader_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shift,
  input  logic [KEY_W-1:0]        digit,
  input  logic                    clr,
  output logic [KEY_W*DIGITS-1:0] entry,
  output logic [2:0]              cnt
);

  localparam int         W       = KEY_W * DIGITS;
  localparam logic [2:0] DIG_LIM = 3'(DIGITS);

  logic [W-1:0] entry_q, entry_d;
  logic [2:0]   cnt_q, cnt_d;

  // Next entry value: clear wins over shift; shifting continues past saturation.
  always_comb begin
    entry_d = entry_q;
    cnt_d   = cnt_q;
    if (clr) begin
      entry_d = '0;
      cnt_d   = 3'd0;
    end else if (shift) begin
      entry_d = {entry_q[W-KEY_W-1:0], digit};
      cnt_d   = sat_inc(cnt_q, DIG_LIM);
    end else begin
      entry_d = entry_q;
      cnt_d   = cnt_q;
    end
  end

  // Entry and count state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q <= '0;
      cnt_q   <= 3'd0;
    end else begin
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign entry = entry_q;
  assign cnt   = cnt_q;

endmodule

// File: rtl/fp_operand_loader.sv
// Keypad operand-entry FSM: builds operands A and B, offers them over valid/ready.
module fp_operand_loader
  import fp_loader_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    digit_valid,
  input  logic [KEY_W-1:0]        digit,
  input  logic                    enter,
  input  logic                    clear,
  input  logic                    op_ready,
  output logic                    op_valid,
  output logic [KEY_W*DIGITS-1:0] op_a,
  output logic [KEY_W*DIGITS-1:0] op_b,
  output logic [KEY_W*DIGITS-1:0] disp_data,
  output logic [2:0]              digit_cnt,
  output logic [1:0]              phase,
  output logic [CNT_W-1:0]        txn_cnt
);

  localparam int W = KEY_W * DIGITS;

  phase_e           state_q;
  logic             op_valid_q;
  logic [W-1:0]     op_a_q, op_b_q;
  logic [CNT_W-1:0] txn_q;

  logic             in_entry_s;
  logic             illegal_s;
  logic             take_clear_s, take_enter_s, take_digit_s;
  logic             entry_clr_s;
  logic [W-1:0]     entry_s;
  logic [2:0]       cnt_s;

  // Strobe decode: strobes only count while entering, clear > enter > digit.
  always_comb begin
    in_entry_s   = 1'b0;
    illegal_s    = 1'b0;
    take_clear_s = 1'b0;
    take_enter_s = 1'b0;
    take_digit_s = 1'b0;
    case (state_q)
      ENTER_A, ENTER_B: in_entry_s = 1'b1;
      ISSUE:            in_entry_s = 1'b0;
      default:          illegal_s  = 1'b1;
    endcase
    if (in_entry_s) begin
      take_clear_s = clear;
      take_enter_s = enter & ~clear;
      take_digit_s = digit_valid & ~enter & ~clear;
    end else begin
      take_clear_s = 1'b0;
      take_enter_s = 1'b0;
      take_digit_s = 1'b0;
    end
    entry_clr_s = take_clear_s | take_enter_s | illegal_s;
  end

  hex_entry_reg #(
    .DIGITS(DIGITS)
  ) u_entry (
    .clk   (clk),
    .rst   (rst),
    .shift (take_digit_s),
    .digit (digit),
    .clr   (entry_clr_s),
    .entry (entry_s),
    .cnt   (cnt_s)
  );

  // Operand-entry FSM with operand capture, handshake and transfer count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ENTER_A;
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      txn_q      <= '0;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (take_clear_s) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            state_q <= ENTER_A;
          end else if (take_enter_s) begin
            op_a_q  <= entry_s;
            state_q <= ENTER_B;
          end else begin
            state_q <= ENTER_A;
          end
        end
        ENTER_B: begin
          if (take_clear_s) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            state_q <= ENTER_A;
          end else if (take_enter_s) begin
            op_b_q     <= entry_s;
            op_valid_q <= 1'b1;
            state_q    <= ISSUE;
          end else begin
            state_q <= ENTER_B;
          end
        end
        ISSUE: begin
          // The offer holds until the MAC takes it; strobes are ignored here.
          if (op_ready) begin
            op_valid_q <= 1'b0;
            txn_q      <= txn_q + CNT_W'(1);
            state_q    <= ENTER_A;
          end else begin
            state_q <= ISSUE;
          end
        end
        default: begin
          op_valid_q <= 1'b0;
          state_q    <= ENTER_A;
        end
      endcase
    end
  end

  assign op_valid  = op_valid_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign disp_data = entry_s;
  assign digit_cnt = cnt_s;
  assign phase     = state_q;
  assign txn_cnt   = txn_q;

endmodule

// File: tb/tb_fp_operand_loader.sv
// Self-checking bench for fp_operand_loader: spec-level model plus directed pins.
module tb_fp_operand_loader;

  localparam int DIGITS = 4;
  localparam int W      = 16;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             digit_valid = 1'b0;
  logic [3:0]       digit = 4'd0;
  logic             enter = 1'b0;
  logic             clear = 1'b0;
  logic             op_ready = 1'b0;
  logic             op_valid;
  logic [W-1:0]     op_a, op_b, disp_data;
  logic [2:0]       digit_cnt;
  logic [1:0]       phase;
  logic [CNT_W-1:0] txn_cnt;

  int total = 0;
  int bad   = 0;

  // Behavioural model state (plain integers).
  int m_entry, m_cnt, m_phase, m_a, m_b, m_valid, m_txn;

  always #5 clk = ~clk;

  fp_operand_loader #(.DIGITS(DIGITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
    .enter(enter), .clear(clear), .op_ready(op_ready), .op_valid(op_valid),
    .op_a(op_a), .op_b(op_b), .disp_data(disp_data), .digit_cnt(digit_cnt),
    .phase(phase), .txn_cnt(txn_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_entry = 0; m_cnt = 0; m_phase = 0; m_a = 0; m_b = 0; m_valid = 0; m_txn = 0;
  endtask

  // One clock of the spec's rules applied to the strobes seen at that edge.
  task automatic model_step(input bit dv, input int d, input bit en, input bit cl, input bit rdy);
    if (m_phase == 2) begin
      if (rdy) begin
        m_valid = 0;
        m_txn   = (m_txn + 1) % 256;
        m_phase = 0;
      end
    end else if (cl) begin
      m_entry = 0; m_cnt = 0; m_a = 0; m_b = 0; m_phase = 0;
    end else if (en) begin
      if (m_phase == 0) begin
        m_a = m_entry; m_phase = 1;
      end else begin
        m_b = m_entry; m_phase = 2; m_valid = 1;
      end
      m_entry = 0; m_cnt = 0;
    end else if (dv) begin
      m_entry = (m_entry * 16 + d) % 65536;
      m_cnt   = (m_cnt < DIGITS) ? m_cnt + 1 : DIGITS;
    end
  endtask

  // Drive strobes for one cycle, advance the model at the edge, settle 1 time unit.
  task automatic step(input bit dv, input int d, input bit en, input bit cl, input bit rdy);
    digit_valid = dv; digit = 4'(d); enter = en; clear = cl; op_ready = rdy;
    @(posedge clk);
    model_step(dv, d, en, cl, rdy);
    #1;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 0, 1'b0, 1'b0, rdy);
  endtask

  task automatic key(input int d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  // Asserts reset at the current time, checks outputs cleared at once, releases off-edge.
  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_op_valid", int'(op_valid), 0);
    check("rst_phase", int'(phase), 0);
    check("rst_op_a", int'(op_a), 0);
    check("rst_op_b", int'(op_b), 0);
    check("rst_disp", int'(disp_data), 0);
    check("rst_cnt", int'(digit_cnt), 0);
    check("rst_txn", int'(txn_cnt), 0);
    @(posedge clk);
    #1;
    digit_valid = 1'b0; enter = 1'b0; clear = 1'b0; op_ready = 1'b0;
    rst = 1'b1;
  endtask

  // Every-cycle compare of the DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      check("op_valid", int'(op_valid), m_valid);
      check("op_a", int'(op_a), m_a);
      check("op_b", int'(op_b), m_b);
      check("disp_data", int'(disp_data), m_entry);
      check("digit_cnt", int'(digit_cnt), m_cnt);
      check("phase", int'(phase), m_phase);
      check("txn_cnt", int'(txn_cnt), m_txn);
    end
  end

  initial begin
    model_reset();
    #2;
    do_reset();

    // Full entry with ready held high.
    key(3); key(12); key(0); key(0);
    check("t1_disp", int'(disp_data), 'h3C00);
    check("t1_cnt", int'(digit_cnt), 4);
    step(1'b0, 0, 1'b1, 1'b0, 1'b1);
    check("t1_op_a", int'(op_a), 'h3C00);
    check("t1_phase_b", int'(phase), 1);
    key(4); key(0); key(0); key(0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b1);
    check("t1_valid_hi", int'(op_valid), 1);
    check("t1_op_b", int'(op_b), 'h4000);
    idle(1'b1);
    check("t1_valid_lo", int'(op_valid), 0);
    check("t1_txn", int'(txn_cnt), 1);
    check("t1_phase_a", int'(phase), 0);

    // Partial entry and overflow.
    key(7);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    check("t2_op_a", int'(op_a), 'h0007);
    key(1); key(2); key(3); key(4); key(5);
    check("t2_disp", int'(disp_data), 'h2345);
    check("t2_cnt", int'(digit_cnt), 4);

    // Backpressure: strobes in ISSUE are ignored, offer is held.
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      check("t3_hold_valid", int'(op_valid), 1);
    end
    check("t3_op_a", int'(op_a), 'h0007);
    check("t3_op_b", int'(op_b), 'h2345);
    idle(1'b1);
    check("t3_txn", int'(txn_cnt), 2);
    check("t3_valid_lo", int'(op_valid), 0);

    // Priority: clear beats enter in ENTER_B; enter beats digit in ENTER_A.
    key(9);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    key(1);
    step(1'b0, 0, 1'b1, 1'b1, 1'b0);
    check("t4_phase", int'(phase), 0);
    check("t4_op_a", int'(op_a), 0);
    check("t4_op_b", int'(op_b), 0);
    key(5);
    step(1'b1, 8, 1'b1, 1'b0, 1'b0);
    check("t4_commit", int'(op_a), 'h0005);
    check("t4_no_digit", int'(disp_data), 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 99) < 50), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 4),
           1'($urandom_range(0, 99) < 40));
    end

    // Reset while an offer is pending.
    idle(1'b0);
    while (m_phase != 2) begin
      step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    end
    check("t6_valid_pending", int'(op_valid), 1);
    #2;
    do_reset();

    // Counter wrap after 256 transfers.
    for (int i = 0; i < 255; i++) begin
      step(1'b0, 0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 0, 1'b1, 1'b0, 1'b0);
      idle(1'b1);
    end
    check("t5_txn_ff", int'(txn_cnt), 'hFF);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    check("t5_txn_wrap", int'(txn_cnt), 0);
    check("t5_phase", int'(phase), 0);
    idle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_operand_loader.md
# fp_operand_loader

Accepts hex digit strobes from the keypad front end, assembles two 16-bit half-precision operands (A then B) with an operator-driven `enter`/`clear` sequence, and offers the pair to the FP MAC datapath over a valid/ready handshake. Sits directly downstream of the keypad reader and replaces free-running shift capture with an explicit, handshaked operand-entry FSM. It also drives a live display word and status for the board LEDs and 7-segment displays.

## Interface
- `DIGITS`, default 4: hex digits per operand; operand width `W = 4*DIGITS`.
- `CNT_W`, default 8: width of the accepted-transaction counter.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset. One clock domain only.
- `digit_valid` in 1: one-cycle strobe; `digit` is a new key.
- `digit` in 4: hex key code 0x0–0xF.
- `enter` in 1: one-cycle strobe; commits the current entry.
- `clear` in 1: one-cycle strobe; aborts the current entry sequence.
- `op_ready` in 1: MAC can accept an operand pair.
- `op_valid` out 1: operand pair offered.
- `op_a` out W: operand A.
- `op_b` out W: operand B.
- `disp_data` out W: current entry register, for the display.
- `digit_cnt` out 3: digits entered so far in the current entry, saturating at `DIGITS`.
- `phase` out 2: FSM state. 0 = ENTER_A, 1 = ENTER_B, 2 = ISSUE.
- `txn_cnt` out CNT_W: count of accepted pairs; wraps.

## Operation
- **Reset:** all outputs and registers are 0; state is ENTER_A.
- **Digit in ENTER_A/ENTER_B:**
  - `entry <= {entry[W-5:0], digit}`.
  - `digit_cnt` increments and saturates at `DIGITS`.
  - Past saturation, shifting continues, so the last `DIGITS` keys are kept.
- **Enter in ENTER_A:**
  - `op_a <= entry`, `entry <= 0`, `digit_cnt <= 0`, next state ENTER_B.
  - Accepted with any `digit_cnt`, including 0. The value is the right-justified partial entry.
- **Enter in ENTER_B:**
  - `op_b <= entry`, entry and count are cleared.
  - Next state ISSUE, with `op_valid <= 1`.
- **ISSUE:**
  - `op_valid` stays high until a cycle with `op_ready` = 1 (the transfer).
  - After the transfer: `op_valid <= 0`, `txn_cnt <= txn_cnt + 1` (modulo 2^CNT_W), next state ENTER_A.
  - `digit_valid`, `enter` and `clear` are ignored in ISSUE. An offered pair is never withdrawn.
- **Clear in ENTER_A/ENTER_B:**
  - Entry, `digit_cnt`, `op_a` and `op_b` go to 0; next state ENTER_A.
  - `txn_cnt` is unaffected.
- **Simultaneous strobes, priority `clear` > `enter` > `digit_valid`:** a lower-priority strobe in the same cycle is dropped. It is not queued.
- **Stability:** `op_a` and `op_b` hold their values while `op_valid` is high, and also afterwards until the next commit.
- **`disp_data`:** always equals `entry`.

## Timing
- All outputs are registered. There is no combinational path from input to output, including `op_ready` → `op_valid`.
- **Digit:** a strobe at edge n updates `disp_data` and `digit_cnt` after edge n.
- **Enter B → `op_valid`:** `enter` sampled at edge n gives `op_valid` = 1 after edge n, so it is high in cycle n+1.
- **Handshake:**
  - A transfer occurs at the first edge where `op_valid` and `op_ready` are both 1. `op_valid` drops after that edge.
  - If `op_ready` is already high, `op_valid` is high for exactly one cycle.
  - A new digit is accepted from the next cycle.
- **Reset mid-ISSUE:** `op_valid` deasserts asynchronously, with no transfer counted. The MAC must treat an offer withdrawn by reset as never sent.
- **Throughput:** at most one pair per 3 cycles (enter A, enter B, transfer).

## Structure
- **Package `fp_loader_pkg`:**
  - state encoding `ENTER_A`=2'd0, `ENTER_B`=2'd1, `ISSUE`=2'd2 (2'd3 is illegal; the FSM recovers to ENTER_A);
  - `KEY_W`=4.
- **Sub-module `hex_entry_reg`:**
  - shift register plus saturating digit counter;
  - inputs: `shift`, `digit`, `clr`;
  - outputs: `entry`, `cnt`.
- **Top level:** FSM, `op_a`/`op_b` capture registers, handshake and `txn_cnt`.

## Test plan
- **Full entry, ready held high:** digits 3,C,0,0, enter, digits 4,0,0,0, enter, `op_ready` = 1. Expect `op_a`=0x3C00, `op_b`=0x4000, `op_valid` high exactly 1 cycle, `txn_cnt`=1, `phase` back to 0.
- **Partial entry and overflow:** digits 7, enter gives `op_a`=0x0007. Then digits 1,2,3,4,5 give `disp_data`=0x2345 and `digit_cnt`=4.
- **Backpressure:** `op_ready` = 0 for 10 cycles after ISSUE. Expect `op_valid` and operands stable throughout, digits/enter/clear ignored, and transfer on the first cycle `op_ready` = 1.
- **Priority:** `clear` and `enter` in the same cycle in ENTER_B gives ENTER_A with operands 0. `enter` and `digit_valid` together in ENTER_A commits the old entry, and the digit does not appear.
- **Wrap:** 256 transactions with CNT_W=8 bring `txn_cnt` back to 0.
- **Reset in ISSUE:** assert `rst` while `op_valid` = 1. Expect all outputs 0 immediately and `phase`=0.
